// File: rtl/aibcr3_phase_gate_seq.sv
// rtl/aibcr3_phase_gate_seq.sv - staggered wake/power-down sequencer for the 8-phase split/align clock path
module aibcr3_phase_gate_seq #(
   parameter int NPH      = 8,
   parameter int SETTLE_W = 8
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_pwrdn_req,
   input  logic [SETTLE_W-1:0] i_cfg_settle,
   input  logic [NPH-1:0]      i_cfg_phase_en,
   output logic                o_split_en,
   output logic [NPH-1:0]      o_gate_en,
   output logic                o_pwrdn_ack,
   output logic                o_active_rdy,
   output logic                o_busy
);

   // Index width covers NPH-1; one extra pointer bit leaves room for the
   // end-of-walk markers (NPH going up, all-ones going down).
   localparam int IW = (NPH > 1) ? $clog2(NPH) : 1;
   localparam int PW = IW + 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(NPH - 1);
   localparam logic [PW-1:0] PTR_END  = PW'(NPH);
   localparam logic [PW-1:0] PTR_DONE = '1;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_WAKE_SPLIT,
      ST_UNGATE,
      ST_ACTIVE,
      ST_GATE,
      ST_SPLIT_OFF
   } state_t;

   state_t              r_state;
   logic [SETTLE_W-1:0] r_settle;
   logic [SETTLE_W-1:0] r_cnt;
   logic [NPH-1:0]      r_mask;
   logic [PW-1:0]       r_ptr;
   logic                r_split_en;
   logic [NPH-1:0]      r_gate_en;
   logic                r_pwrdn_ack;
   logic                r_active_rdy;
   logic                r_busy;
   logic [IW-1:0]       w_idx;

   assign w_idx        = r_ptr[IW-1:0];
   assign o_split_en   = r_split_en;
   assign o_gate_en    = r_gate_en;
   assign o_pwrdn_ack  = r_pwrdn_ack;
   assign o_active_rdy = r_active_rdy;
   assign o_busy       = r_busy;

   // Sequencer FSM: one gate_en bit changes per cycle at most, and split_en
   // brackets every cycle in which any phase may be running.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= ST_OFF;
         r_settle     <= '0;
         r_cnt        <= '0;
         r_mask       <= '0;
         r_ptr        <= '0;
         r_split_en   <= 1'b0;
         r_gate_en    <= '0;
         r_pwrdn_ack  <= 1'b1;
         r_active_rdy <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_OFF: begin
               if (!i_pwrdn_req) begin
                  r_state     <= ST_WAKE_SPLIT;
                  r_settle    <= i_cfg_settle;
                  r_mask      <= i_cfg_phase_en;
                  r_cnt       <= i_cfg_settle;
                  r_split_en  <= 1'b1;
                  r_pwrdn_ack <= 1'b0;
                  r_busy      <= 1'b1;
               end
            end
            ST_WAKE_SPLIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - SETTLE_W'(1);
               end else begin
                  r_state <= ST_UNGATE;
                  r_ptr   <= '0;
               end
            end
            ST_UNGATE: begin
               // Masked phases still take their slot so latency is fixed.
               if (r_ptr == PTR_END) begin
                  r_state      <= ST_ACTIVE;
                  r_active_rdy <= 1'b1;
                  r_busy       <= 1'b0;
               end else begin
                  r_gate_en[w_idx] <= r_mask[w_idx];
                  r_ptr            <= r_ptr + PW'(1);
               end
            end
            ST_ACTIVE: begin
               if (i_pwrdn_req) begin
                  r_state      <= ST_GATE;
                  r_ptr        <= PTR_LAST;
                  r_settle     <= i_cfg_settle;
                  r_active_rdy <= 1'b0;
                  r_busy       <= 1'b1;
               end
            end
            ST_GATE: begin
               // Phases close in reverse order of opening.
               if (r_ptr == PTR_DONE) begin
                  r_state <= ST_SPLIT_OFF;
                  r_cnt   <= r_settle;
               end else begin
                  r_gate_en[w_idx] <= 1'b0;
                  r_ptr            <= r_ptr - PW'(1);
               end
            end
            ST_SPLIT_OFF: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - SETTLE_W'(1);
               end else begin
                  r_state     <= ST_OFF;
                  r_split_en  <= 1'b0;
                  r_pwrdn_ack <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state      <= ST_OFF;
               r_split_en   <= 1'b0;
               r_gate_en    <= '0;
               r_pwrdn_ack  <= 1'b1;
               r_active_rdy <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aibcr3_phase_gate_seq.sv
// tb/tb_aibcr3_phase_gate_seq.sv - directed self-checking bench for aibcr3_phase_gate_seq
module tb_aibcr3_phase_gate_seq;

   localparam int NPH = 8;

   logic       clk;
   logic       reset;
   logic       pwrdn_req;
   logic [7:0] cfg_settle;
   logic [7:0] cfg_phase_en;
   logic       split_en;
   logic [7:0] gate_en;
   logic       pwrdn_ack;
   logic       active_rdy;
   logic       busy;

   int total = 0;
   int bad   = 0;

   aibcr3_phase_gate_seq #(.NPH(NPH), .SETTLE_W(8)) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_pwrdn_req    (pwrdn_req),
      .i_cfg_settle   (cfg_settle),
      .i_cfg_phase_en (cfg_phase_en),
      .o_split_en     (split_en),
      .o_gate_en      (gate_en),
      .o_pwrdn_ack    (pwrdn_ack),
      .o_active_rdy   (active_rdy),
      .o_busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare {split_en, gate_en, pwrdn_ack, active_rdy, busy} against expectation.
   task automatic chk(input string tag, input int e, input logic [11:0] exp);
      logic [11:0] obs;
      obs = {split_en, gate_en, pwrdn_ack, active_rdy, busy};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s edge=%0d observed=%h expected=%h", tag, e, obs, exp);
      end
   endtask

   task automatic chk_step(input string tag, input int e, input logic [7:0] prev);
      total++;
      assert ($countones(gate_en ^ prev) <= 1) else begin
         bad++;
         $error("FAIL %s edge=%0d observed_change=%h expected=at_most_one_bit", tag, e, gate_en ^ prev);
      end
   endtask

   function automatic logic [11:0] wake_exp(input int s, input logic [7:0] m, input int e);
      logic [7:0] g;
      logic       rdy;
      g = 8'h00;
      for (int k = 0; k < NPH; k++)
         if (m[k] && e >= s + 2 + k) g[k] = 1'b1;
      rdy = (e >= s + NPH + 2);
      return {1'b1, g, 1'b0, rdy, ~rdy};
   endfunction

   function automatic logic [11:0] pd_exp(input int s, input logic [7:0] g0, input int e);
      logic [7:0] g;
      logic       done;
      g = g0;
      for (int j = 0; j < NPH; j++)
         if (e >= NPH - j) g[j] = 1'b0;
      done = (e >= NPH + s + 2);
      return {~done, g, done, 1'b0, ~done};
   endfunction

   // Caller sets inputs; the next rising edge is edge 0.
   task automatic run_wake(input string tag, input int s, input logic [7:0] m, input int last);
      logic [7:0] prev;
      prev = 8'h00;
      for (int e = 0; e <= last; e++) begin
         tick();
         chk(tag, e, wake_exp(s, m, e));
         chk_step(tag, e, prev);
         prev = gate_en;
      end
   endtask

   task automatic run_pwrdn(input string tag, input int s, input logic [7:0] g0, input int last);
      logic [7:0] prev;
      prev = g0;
      for (int e = 0; e <= last; e++) begin
         tick();
         chk(tag, e, pd_exp(s, g0, e));
         chk_step(tag, e, prev);
         prev = gate_en;
      end
   endtask

   initial begin
      reset        = 1'b1;
      pwrdn_req    = 1'b1;
      cfg_settle   = 8'd3;
      cfg_phase_en = 8'hFF;

      // Reset and idle OFF with power-down requested.
      #2;
      chk("reset_async", 0, 12'b0_00000000_1_0_0);
      tick();
      tick();
      reset = 1'b0;
      for (int e = 0; e < 20; e++) begin
         tick();
         chk("off_hold", e, 12'b0_00000000_1_0_0);
      end

      // Wake S=3, all phases.
      cfg_settle   = 8'd3;
      cfg_phase_en = 8'hFF;
      pwrdn_req    = 1'b0;
      run_wake("wake_s3", 3, 8'hFF, 13);

      // Config changes while ACTIVE are ignored.
      cfg_phase_en = 8'h00;
      cfg_settle   = 8'd9;
      for (int e = 0; e < 3; e++) begin
         tick();
         chk("active_hold", e, 12'b1_11111111_0_1_0);
      end

      // Power-down S=0.
      cfg_settle = 8'd0;
      pwrdn_req  = 1'b1;
      run_pwrdn("pd_s0", 0, 8'hFF, 12);

      // Mask 0xA5, S=0: timing unchanged.
      cfg_settle   = 8'd0;
      cfg_phase_en = 8'hA5;
      pwrdn_req    = 1'b0;
      run_wake("wake_a5", 0, 8'hA5, 11);
      pwrdn_req = 1'b1;
      run_pwrdn("pd_a5", 0, 8'hA5, 11);

      // Zero mask: ACTIVE reached with nothing running, same latency.
      cfg_settle   = 8'd1;
      cfg_phase_en = 8'h00;
      pwrdn_req    = 1'b0;
      run_wake("wake_m0", 1, 8'h00, 11);
      pwrdn_req = 1'b1;
      run_pwrdn("pd_m0", 1, 8'h00, 12);

      // Maximum settle count, both directions.
      cfg_settle   = 8'd255;
      cfg_phase_en = 8'hFF;
      pwrdn_req    = 1'b0;
      run_wake("wake_s255", 255, 8'hFF, 266);
      pwrdn_req = 1'b1;
      run_pwrdn("pd_s255", 255, 8'hFF, 266);

      // Request reversal during WAKE_SPLIT (S=5): no abort, then GATE.
      cfg_settle   = 8'd5;
      cfg_phase_en = 8'hFF;
      pwrdn_req    = 1'b0;
      for (int e = 0; e <= 33; e++) begin
         tick();
         if (e <= 15) chk("reversal", e, wake_exp(5, 8'hFF, e));
         else         chk("reversal", e, pd_exp(5, 8'hFF, e - 16));
         if (e == 2) pwrdn_req = 1'b1;
      end

      // Async reset mid-UNGATE (S=2, edge S+4), then a clean restart.
      cfg_settle   = 8'd2;
      cfg_phase_en = 8'hFF;
      pwrdn_req    = 1'b0;
      run_wake("wake_pre_rst", 2, 8'hFF, 6);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst", 0, 12'b0_00000000_1_0_0);
      #2;
      reset = 1'b0;
      run_wake("wake_post_rst", 2, 8'hFF, 13);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
